// File: rtl/moving_average_pow2.sv
// Boxcar moving-average filter with a runtime-selectable power-of-two window.
// It keeps a running sum over a circular sample history and can optionally round the result half-up.
module moving_average_pow2 #(
  parameter int DATA_W         = 10,
  parameter int LOG2_MAX_DEPTH = 3,
  parameter int SEL_W          = 2,
  parameter int ROUND          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [SEL_W-1:0]  win_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe_in,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              primed
);

  localparam int MAX_DEPTH = 1 << LOG2_MAX_DEPTH;
  localparam int LW        = (LOG2_MAX_DEPTH > 0) ? $clog2(LOG2_MAX_DEPTH + 1) : 1;
  localparam int FILL_W    = LOG2_MAX_DEPTH + 1;
  localparam int SUM_W     = DATA_W + LOG2_MAX_DEPTH;
  localparam int RND_W     = SUM_W + 1;

  logic [DATA_W-1:0]         r_buf [MAX_DEPTH];
  logic [LOG2_MAX_DEPTH-1:0] r_wr_ptr;
  logic [FILL_W-1:0]         r_fill;
  logic [SUM_W-1:0]          r_sum;
  logic [LW-1:0]             r_win_q;
  logic [DATA_W-1:0]         r_data_out;
  logic                      r_strobe_out;
  logic                      r_primed;

  logic [31:0]               w_sel_ext;
  logic [LW-1:0]             w_sel_clamped;
  logic                      w_accept;
  logic                      w_flush;
  logic [LW-1:0]             w_log2n;
  logic [FILL_W-1:0]         w_n;
  logic [FILL_W-1:0]         w_fill_cur;
  logic [SUM_W-1:0]          w_sum_cur;
  logic [LOG2_MAX_DEPTH-1:0] w_old_idx;
  logic [DATA_W-1:0]         w_old;
  logic [SUM_W-1:0]          w_sum_next;
  logic [FILL_W-1:0]         w_fill_next;
  logic [RND_W-1:0]          w_half;
  logic [RND_W-1:0]          w_rounded;
  logic [DATA_W-1:0]         w_avg;

  assign w_sel_ext     = 32'(win_sel);
  assign w_sel_clamped = (w_sel_ext > 32'(LOG2_MAX_DEPTH)) ? LW'(LOG2_MAX_DEPTH) : LW'(w_sel_ext);

  assign w_accept = ena & strobe_in;
  assign w_flush  = ena & (w_sel_clamped != r_win_q);

  // A strobe coinciding with a window change is the first sample of the new window.
  assign w_log2n    = w_flush ? w_sel_clamped : r_win_q;
  assign w_n        = FILL_W'(1) << w_log2n;
  assign w_fill_cur = w_flush ? '0 : r_fill;
  assign w_sum_cur  = w_flush ? '0 : r_sum;

  assign w_old_idx   = r_wr_ptr - w_n[LOG2_MAX_DEPTH-1:0];
  assign w_old       = (w_fill_cur >= w_n) ? r_buf[w_old_idx] : '0;
  assign w_sum_next  = w_sum_cur + SUM_W'(data_in) - SUM_W'(w_old);
  assign w_fill_next = (w_fill_cur == FILL_W'(MAX_DEPTH)) ? w_fill_cur : w_fill_cur + FILL_W'(1);

  assign w_half    = (ROUND != 0) ? RND_W'(w_n >> 1) : '0;
  assign w_rounded = RND_W'(w_sum_next) + w_half;
  assign w_avg     = DATA_W'(w_rounded >> w_log2n);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= data_in;
    end
  end

  // On reset the window register takes a fixed value. The first enabled cycle then loads the live
  // selection through the flush path. The history is already empty at that point, so the outputs are
  // the same as if the register had captured win_sel during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_sum        <= '0;
      r_win_q      <= '0;
      r_data_out   <= '0;
      r_strobe_out <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_strobe_out <= w_accept;
      if (w_flush) begin
        r_win_q  <= w_sel_clamped;
        r_sum    <= '0;
        r_fill   <= '0;
        r_primed <= 1'b0;
      end
      if (w_accept) begin
        r_sum      <= w_sum_next;
        r_fill     <= w_fill_next;
        r_wr_ptr   <= r_wr_ptr + LOG2_MAX_DEPTH'(1);
        r_data_out <= w_avg;
        r_primed   <= (w_fill_next >= w_n);
      end
    end
  end

  assign data_out   = r_data_out;
  assign strobe_out = r_strobe_out;
  assign primed     = r_primed;

endmodule

// File: tb/tb_moving_average_pow2.sv
// Checks moving_average_pow2 against a sample-history model of the boxcar average.
// Two instances share the stimulus: (depth 8, rounding) and (depth 4, truncation, clamps win_sel=3).
module tb_moving_average_pow2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       strobe_in = 1'b0;
  logic [1:0] win_sel = 2'd0;
  logic [9:0] data_in = 10'd0;
  logic [9:0] dout0, dout1;
  logic       stb0, stb1, pr0, pr1;

  int n_vec = 0;
  int n_err = 0;

  int m_win [2];
  int m_cnt [2];
  int m_hist [2][8];
  int exp_out [2];
  bit exp_stb [2];
  bit exp_pr [2];

  always #5 clk = ~clk;

  moving_average_pow2 #(.DATA_W(10), .LOG2_MAX_DEPTH(3), .SEL_W(2), .ROUND(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .win_sel(win_sel), .data_in(data_in),
    .strobe_in(strobe_in), .data_out(dout0), .strobe_out(stb0), .primed(pr0)
  );

  moving_average_pow2 #(.DATA_W(10), .LOG2_MAX_DEPTH(2), .SEL_W(2), .ROUND(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .win_sel(win_sel), .data_in(data_in),
    .strobe_in(strobe_in), .data_out(dout1), .strobe_out(stb1), .primed(pr1)
  );

  function automatic int clampf(input int s, input int d);
    int lg;
    lg = (d == 0) ? 3 : 2;
    return (s > lg) ? lg : s;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  // The average is recomputed directly from the most recent samples accepted since the last reset or flush.
  task automatic model_step(input int d);
    int c, n, s;
    exp_stb[d] = 1'b0;
    if (ena !== 1'b1) return;
    c = clampf(int'(win_sel), d);
    if (c != m_win[d]) begin
      m_win[d] = c;
      m_cnt[d] = 0;
      exp_pr[d] = 1'b0;
    end
    if (strobe_in === 1'b1) begin
      for (int i = 7; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
      m_hist[d][0] = int'(data_in);
      if (m_cnt[d] < 8) m_cnt[d]++;
      n = 1 << m_win[d];
      s = 0;
      for (int i = 0; i < n; i++) if (i < m_cnt[d]) s += m_hist[d][i];
      if (d == 0) s += n / 2;
      exp_out[d] = s >> m_win[d];
      exp_pr[d]  = (m_cnt[d] >= n);
      exp_stb[d] = 1'b1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      exp_out[d] = 0; exp_stb[d] = 1'b0; exp_pr[d] = 1'b0; m_cnt[d] = 0; m_win[d] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (rst_n !== 1'b1) begin
          m_win[d] = clampf(int'(win_sel), d);
          m_cnt[d] = 0;
          exp_out[d] = 0;
          exp_stb[d] = 1'b0;
          exp_pr[d] = 1'b0;
        end else begin
          model_step(d);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_dout0", int'(dout0), exp_out[0]);
      chk("model_stb0", int'(stb0), int'(exp_stb[0]));
      chk("model_pr0", int'(pr0), int'(exp_pr[0]));
      chk("model_dout1", int'(dout1), exp_out[1]);
      chk("model_stb1", int'(stb1), int'(exp_stb[1]));
      chk("model_pr1", int'(pr1), int'(exp_pr[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int d);
    strobe_in = 1'b1;
    data_in = 10'(d);
    tick();
    strobe_in = 1'b0;
  endtask

  task automatic reset_pulse(input logic [1:0] sel);
    rst_n = 1'b0;
    win_sel = sel;
    #1;
    chk("async_rst_dout0", int'(dout0), 0);
    chk("async_rst_stb0", int'(stb0), 0);
    chk("async_rst_pr0", int'(pr0), 0);
    chk("async_rst_dout1", int'(dout1), 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int e0 [9];
    e0 = '{128, 256, 384, 512, 639, 767, 895, 1023, 1023};

    rst_n = 1'b0; win_sel = 2'd2; ena = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_dout0", int'(dout0), 0);
    chk("reset_pr0", int'(pr0), 0);

    // Impulse response, N=4
    repeat (11) send(0);
    send(1023);
    chk("impulse0_k0", int'(dout0), 256);
    chk("impulse1_k0", int'(dout1), 255);
    for (int j = 1; j <= 5; j++) begin
      send(0);
      chk("impulse0", int'(dout0), (j < 4) ? 256 : 0);
      chk("impulse1", int'(dout1), (j < 4) ? 255 : 0);
    end

    // Step response, N=8 (second instance clamps to N=4)
    reset_pulse(2'd3);
    for (int k = 0; k < 9; k++) begin
      send(1023);
      chk("step0", int'(dout0), e0[k]);
      chk("step0_primed", int'(pr0), (k >= 7) ? 1 : 0);
      chk("step1", int'(dout1), (k < 4) ? ((k + 1) * 1023) / 4 : 1023);
      chk("step1_primed", int'(pr1), (k >= 3) ? 1 : 0);
    end

    // Flush on a window change that coincides with a strobe
    reset_pulse(2'd3);
    repeat (8) send(100);
    chk("flush_pre0", int'(dout0), 100);
    chk("flush_pre_primed0", int'(pr0), 1);
    win_sel = 2'd1;
    send(100);
    chk("flush_first0", int'(dout0), 50);
    chk("flush_first_primed0", int'(pr0), 0);
    chk("flush_first1", int'(dout1), 50);
    send(100);
    chk("flush_second0", int'(dout0), 100);
    chk("flush_second_primed0", int'(pr0), 1);
    send(100);
    chk("flush_third0", int'(dout0), 100);

    // Gating: strobes and window changes ignored while disabled
    ena = 1'b0;
    win_sel = 2'd3;
    strobe_in = 1'b1;
    data_in = 10'd500;
    repeat (4) begin
      tick();
      chk("gated_stb0", int'(stb0), 0);
      chk("gated_hold0", int'(dout0), 100);
    end
    strobe_in = 1'b0;
    win_sel = 2'd1;
    ena = 1'b1;
    send(100);
    chk("ungated_dout0", int'(dout0), 100);
    chk("ungated_primed0", int'(pr0), 1);

    // Reset in the middle of a strobe stream
    strobe_in = 1'b1;
    data_in = 10'd700;
    reset_pulse(2'd3);
    strobe_in = 1'b0;
    send(1023);
    chk("post_reset_step0", int'(dout0), 128);
    chk("post_reset_step1", int'(dout1), 255);

    // Back-to-back ramp exercises pointer wrap on both depths
    reset_pulse(2'd3);
    for (int k = 0; k < 20; k++) begin
      send(k);
      if (k >= 3) chk("ramp1", int'(dout1), k - 2);
      if (k >= 7) chk("ramp0", int'(dout0), k - 3);
    end
    chk("ramp_end0", int'(dout0), 16);
    chk("ramp_end1", int'(dout1), 17);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(0, 9) != 0);
      strobe_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: data_in = 10'd1023;
        1: data_in = 10'd0;
        default: data_in = 10'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 39) == 0) win_sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    strobe_in = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
